// File: rtl/pulse_train_generator.sv
// Pulse-train transmitter: START/STOP commands drive pulse_out; completion reports go to an RTI FIFO.
// Optional feature: define PULSE_TRAIN_REPORT_EN to build the report path (write / count_out).
module pulse_train_generator #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [63:0]  cmd_in,
    input  logic         cmd_valid,
    input  logic [63:0]  counter,
    output logic         pulse_out,
    output logic         busy,
    output logic         busy_error,
    output logic         write,
    output logic [127:0] count_out
);
    localparam logic [3:0] OP_START     = 4'h1;
    localparam logic [3:0] OP_STOP      = 4'h2;
    localparam logic [3:0] STAT_DONE    = 4'h1;
    localparam logic [3:0] STAT_STOPPED = 4'h2;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] n_q, h_q, l_q, e_q, phase_q;
    logic [DATA_WIDTH-1:0] e_n, phase_n;
    logic [DATA_WIDTH-1:0] cmd_n, cmd_h, cmd_l, cmd_h_m1, cmd_l_m1;
    logic                  start, stop, load, berr_set;
    logic                  rep_wr;
    logic [3:0]            rep_status;
    logic [DATA_WIDTH-1:0] rep_e;

    assign start = cmd_valid && (cmd_in[63:60] == OP_START);
    assign stop  = cmd_valid && (cmd_in[63:60] == OP_STOP);
    assign cmd_n = cmd_in[DATA_WIDTH-1:0];
    assign cmd_h = cmd_in[2*DATA_WIDTH-1:DATA_WIDTH];
    assign cmd_l = cmd_in[3*DATA_WIDTH-1:2*DATA_WIDTH];

    // Zero lengths behave as one cycle; store reload values (length - 1) directly.
    assign cmd_h_m1 = (cmd_h == '0) ? '0 : cmd_h - DATA_WIDTH'(1);
    assign cmd_l_m1 = (cmd_l == '0) ? '0 : cmd_l - DATA_WIDTH'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            n_q        <= '0;
            h_q        <= '0;
            l_q        <= '0;
            e_q        <= '0;
            phase_q    <= '0;
            pulse_out  <= 1'b0;
            busy       <= 1'b0;
            busy_error <= 1'b0;
        end else begin
            state   <= state_n;
            e_q     <= e_n;
            phase_q <= phase_n;
            if (load) begin
                n_q <= cmd_n;
                h_q <= cmd_h_m1;
                l_q <= cmd_l_m1;
            end
            pulse_out <= (state_n == HIGH);
            busy      <= (state_n != IDLE);
            if (berr_set)
                busy_error <= 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        e_n        = e_q;
        phase_n    = phase_q;
        load       = 1'b0;
        berr_set   = 1'b0;
        rep_wr     = 1'b0;
        rep_status = STAT_DONE;
        rep_e      = e_q;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cmd_n != '0) begin
                        state_n = HIGH;
                        phase_n = cmd_h_m1;
                        e_n     = DATA_WIDTH'(1);
                        load    = 1'b1;
                    end else begin
                        rep_wr = 1'b1;
                        rep_e  = '0;
                    end
                end
            end
            HIGH: begin
                berr_set = start;
                // Completion wins over STOP in the final high cycle.
                if (phase_q == '0 && e_q == n_q) begin
                    state_n = IDLE;
                    rep_wr  = 1'b1;
                end else if (stop) begin
                    state_n    = IDLE;
                    rep_wr     = 1'b1;
                    rep_status = STAT_STOPPED;
                end else if (phase_q == '0) begin
                    state_n = LOW;
                    phase_n = l_q;
                end else begin
                    phase_n = phase_q - DATA_WIDTH'(1);
                end
            end
            LOW: begin
                berr_set = start;
                if (stop) begin
                    state_n    = IDLE;
                    rep_wr     = 1'b1;
                    rep_status = STAT_STOPPED;
                end else if (phase_q == '0) begin
                    state_n = HIGH;
                    phase_n = h_q;
                    e_n     = e_q + DATA_WIDTH'(1);
                end else begin
                    phase_n = phase_q - DATA_WIDTH'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef PULSE_TRAIN_REPORT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write     <= 1'b0;
            count_out <= '0;
        end else begin
            write <= rep_wr;
            if (rep_wr)
                count_out <= {counter, rep_status, {(60-DATA_WIDTH){1'b0}}, rep_e};
        end
    end

    logic lint_unused;
    assign lint_unused = ^cmd_in;
`else
    assign write     = 1'b0;
    assign count_out = '0;

    logic lint_unused;
    assign lint_unused = ^{cmd_in, counter, rep_wr, rep_status, rep_e};
`endif

endmodule
